taxi_meter_ctrl: RTL
====================

# taxi_meter_ctrl

Trip controller for the taxi fare meter. It runs the meter state machine (vacant, hired, stopped) and gates the wait-time counter. It also merges distance events and wait-fare events into one saturating fare accumulator. The block sits between the pulse generators (distance sensor, per-minute wait counter) and the fare display driver.

## Interface
Parameters:
- BASE_FARE, 100: fare loaded at trip start, in units of 0.1 yuan.
- BASE_DIST, 30: distance events covered by the base fare (one event = 100 m).
- RATE_DIST, 2: fare added per distance event beyond BASE_DIST.
- RATE_WAIT, 20: fare added per wait-fare event.
- FARE_MAX, 9999: saturation ceiling for the fare.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset; asynchronous, active-low.
- start_btn, input, 1: single-cycle, clk-synchronous; begins a new trip.
- stop_btn, input, 1: single-cycle, clk-synchronous; ends the trip and freezes the fare.
- clear_btn, input, 1: single-cycle, clk-synchronous; returns the meter to vacant.
- moving, input, 1: asynchronous level; high while the wheels turn.
- dist_pulse, input, 1: asynchronous; each rising edge is one 100 m event.
- wait_tgl, input, 1: asynchronous; every edge (rise or fall) is one wait-fare event.
- fare, output, 14: current fare in 0.1 yuan units, binary.
- dist_cnt, output, 10: distance events this trip; saturates at 1023.
- state_o, output, 2: 0 = VACANT, 1 = HIRED, 2 = STOPPED.
- wait_cnt_rst_n, output, 1: registered, active-low hold for the wait counter.

## Operation
- FSM transitions:
  - VACANT + start_btn → HIRED: fare <= BASE_FARE, dist_cnt <= 0.
  - HIRED + stop_btn → STOPPED: fare and dist_cnt frozen.
  - STOPPED + start_btn → HIRED: new trip, same load as from VACANT.
  - STOPPED + clear_btn → VACANT: fare <= 0, dist_cnt <= 0.
  - All other button combinations are ignored.
- Button priority: in HIRED, stop_btn wins over a simultaneous start_btn. In STOPPED, start_btn wins over clear_btn. clear_btn has no effect in HIRED.
- Events count only in HIRED. Events detected in VACANT or STOPPED are discarded.
- Distance event: dist_cnt increments. If the pre-increment dist_cnt is at least BASE_DIST, fare adds RATE_DIST; otherwise fare is unchanged.
- Wait event: fare adds RATE_WAIT.
- A distance event and a wait event in the same cycle are both applied in that cycle; the increments are summed.
- Arithmetic: the sum is computed at 15 bits. If the result exceeds FARE_MAX, fare <= FARE_MAX and holds there.
- An event coincident with a stop_btn that leaves HIRED is still applied to the frozen fare.
- An event coincident with start_btn (trip load) is discarded; the fare is exactly BASE_FARE.
- wait_cnt_rst_n <= (state == HIRED) && !moving_sync. It is registered, so it is glitch-free. The wait counter is held in reset otherwise, so each stationary stretch restarts its period.
- Reset values: state VACANT, fare 0, dist_cnt 0, wait_cnt_rst_n 0, all synchroniser flops 0.

## Timing
- Asynchronous inputs (moving, dist_pulse, wait_tgl) pass through a 2-flop synchroniser, then an edge-detect register.
- Count the first clk edge that samples a new input level as edge 1. fare and dist_cnt update on edge 3. wait_cnt_rst_n responds to moving on edge 3.
- Button-driven state and register loads take effect on the clk edge where the button is high. state_o is a direct register.
- Minimum event spacing is 3 clk periods. The distance pulse and wait toggle must each stay stable for at least 2 clk periods.
- Asserting rst_n low mid-trip clears everything immediately. In-flight synchroniser contents are lost, and no event is credited after release.

## Configuration
- NIGHT_RATE_EN defined:
  - Adds input port night (1 bit, asynchronous level, synchronised like moving).
  - While night_sync is high, each distance event beyond BASE_DIST adds RATE_DIST_NIGHT (package constant, 3) instead of RATE_DIST.
  - Wait events are unaffected.
- NIGHT_RATE_EN undefined: no night port; the fare always uses RATE_DIST.

## Structure
- Package taxi_pkg holds:
  - The state encoding constants (VACANT, HIRED, STOPPED).
  - FARE_W = 14 and DIST_W = 10.
  - RATE_DIST_NIGHT.
- Sub-module evt_sync: 2-flop synchroniser plus edge detect, with parameter BOTH_EDGES. It is used for:
  - dist_pulse (rising edge only).
  - wait_tgl (both edges).
  - moving (level output only).

## Test plan
- Trip with distance only: start_btn, then 35 dist_pulse rising edges with moving = 1, then stop_btn. Expect fare = 110, dist_cnt = 35, state_o = 2.
- Waiting: start_btn, moving = 0, 3 wait_tgl edges. Expect wait_cnt_rst_n = 1 from edge 3 onward and fare = 160. Raise moving: wait_cnt_rst_n = 0 after 3 clk.
- Simultaneous events and saturation:
  - dist_pulse and wait_tgl edges on the same clk with dist_cnt = 40: fare rises by 22 in one cycle.
  - Preload fare to 9995, then one wait event: fare = 9999 and stays there.
- Events outside HIRED:
  - Events in VACANT and STOPPED: fare unchanged.
  - start_btn and stop_btn together in HIRED: goes to STOPPED.
  - In STOPPED, start_btn then clear_btn: new trip with fare = 100; clear_btn is ignored.
- Reset mid-trip: rst_n low during HIRED with an edge in the synchroniser. Expect all outputs at reset values, no fare change after release, and VACANT until start_btn.
- Night rate: with NIGHT_RATE_EN defined and night = 1, 32 distance events give fare = 106. Without the macro the same stimulus gives fare = 104.

Source files
------------

// File: rtl/taxi_pkg.sv
// Package: taxi_pkg
// Shared definitions for the taxi fare meter trip controller:
//   - state_e          : meter state encoding (VACANT, HIRED, STOPPED)
//   - FARE_W, DIST_W   : fare and distance counter widths
//   - RATE_DIST_NIGHT  : night distance rate (used when NIGHT_RATE_EN is defined)
//   - sat_add()        : 15-bit add of fare and increment, clamped at a ceiling
package taxi_pkg;

  localparam int FARE_W          = 14;
  localparam int DIST_W          = 10;
  localparam int RATE_DIST_NIGHT = 3;

  typedef enum logic [1:0] {
    VACANT  = 2'd0,
    HIRED   = 2'd1,
    STOPPED = 2'd2
  } state_e;

  // The sum is formed one bit wider than the fare so that an overflow of
  // the 14-bit range is still seen by the ceiling comparison.
  function automatic logic [FARE_W-1:0] sat_add(input logic [FARE_W-1:0] base,
                                                 input logic [FARE_W-1:0] inc,
                                                 input logic [FARE_W-1:0] lim);
    logic [FARE_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    if (sum > {1'b0, lim}) begin
      return lim;
    end else begin
      return sum[FARE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/evt_sync.sv
// Module: evt_sync
// Two-flop synchroniser followed by an edge-detect register for one
// asynchronous input.
// Parameters:
//   BOTH_EDGES : 1 = evt on any level change, 0 = evt on rising edge only
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (all flops cleared to 0)
//   din   : asynchronous input
//   level : synchronised level of din
//   evt   : one-cycle event, valid in the cycle after level changes
module evt_sync #(
  parameter bit BOTH_EDGES = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic evt
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchroniser chain plus the previous-level register used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign level = sync_r;

  generate
    if (BOTH_EDGES) begin : g_both
      assign evt = sync_r ^ prev_r;
    end else begin : g_rise
      assign evt = sync_r & ~prev_r;
    end
  endgenerate

endmodule

// File: rtl/taxi_meter_ctrl.sv
// Module: taxi_meter_ctrl
// Trip controller for the taxi fare meter: runs the VACANT/HIRED/STOPPED
// state machine, merges distance and wait-fare events into a saturating
// fare accumulator, and produces the registered wait-counter hold.
// Optional feature macro: NIGHT_RATE_EN (adds the night input; while it is
// high, distance events beyond the base distance add RATE_DIST_NIGHT).
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   start_btn, stop_btn, clear_btn  : single-cycle synchronous buttons
//   moving, dist_pulse, wait_tgl    : asynchronous sensor inputs
//   night (NIGHT_RATE_EN only)      : asynchronous night-tariff level
//   fare                            : fare in 0.1 yuan units
//   dist_cnt                        : 100 m events this trip, saturating
//   state_o                         : 0 VACANT, 1 HIRED, 2 STOPPED
//   wait_cnt_rst_n                  : registered active-low wait counter hold
module taxi_meter_ctrl
  import taxi_pkg::*;
#(
  parameter int BASE_FARE = 100,
  parameter int BASE_DIST = 30,
  parameter int RATE_DIST = 2,
  parameter int RATE_WAIT = 20,
  parameter int FARE_MAX  = 9999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_btn,
  input  logic              stop_btn,
  input  logic              clear_btn,
  input  logic              moving,
  input  logic              dist_pulse,
  input  logic              wait_tgl,
`ifdef NIGHT_RATE_EN
  input  logic              night,
`endif
  output logic [FARE_W-1:0] fare,
  output logic [DIST_W-1:0] dist_cnt,
  output logic [1:0]        state_o,
  output logic              wait_cnt_rst_n
);

  localparam logic [FARE_W-1:0] BASE_FARE_C  = FARE_W'(BASE_FARE);
  localparam logic [FARE_W-1:0] RATE_DIST_C  = FARE_W'(RATE_DIST);
  localparam logic [FARE_W-1:0] RATE_WAIT_C  = FARE_W'(RATE_WAIT);
  localparam logic [FARE_W-1:0] FARE_MAX_C   = FARE_W'(FARE_MAX);
  localparam logic [DIST_W-1:0] BASE_DIST_C  = DIST_W'(BASE_DIST);
  localparam logic [DIST_W-1:0] DIST_SAT_C   = {DIST_W{1'b1}};
`ifdef NIGHT_RATE_EN
  localparam logic [FARE_W-1:0] RATE_NIGHT_C = FARE_W'(RATE_DIST_NIGHT);
`endif

  state_e            state_r,  state_nxt_s;
  logic [FARE_W-1:0] fare_r,   fare_nxt_s;
  logic [DIST_W-1:0] dist_r,   dist_nxt_s;
  logic              wait_rst_r, wait_rst_nxt_s;

  logic              dist_evt_s;
  logic              wait_evt_s;
  logic              moving_lvl_s;
  logic              unused_dist_lvl_s;
  logic              unused_wait_lvl_s;
  logic              unused_moving_evt_s;
  logic [FARE_W-1:0] dist_rate_s;
  logic [FARE_W-1:0] dist_inc_s;
  logic [FARE_W-1:0] wait_inc_s;
  logic [FARE_W-1:0] inc_s;

  evt_sync #(.BOTH_EDGES(1'b0)) u_dist_sync (
    .clk(clk), .rst_n(rst_n), .din(dist_pulse),
    .level(unused_dist_lvl_s), .evt(dist_evt_s)
  );

  evt_sync #(.BOTH_EDGES(1'b1)) u_wait_sync (
    .clk(clk), .rst_n(rst_n), .din(wait_tgl),
    .level(unused_wait_lvl_s), .evt(wait_evt_s)
  );

  evt_sync #(.BOTH_EDGES(1'b0)) u_moving_sync (
    .clk(clk), .rst_n(rst_n), .din(moving),
    .level(moving_lvl_s), .evt(unused_moving_evt_s)
  );

`ifdef NIGHT_RATE_EN
  logic night_lvl_s;
  logic unused_night_evt_s;

  evt_sync #(.BOTH_EDGES(1'b0)) u_night_sync (
    .clk(clk), .rst_n(rst_n), .din(night),
    .level(night_lvl_s), .evt(unused_night_evt_s)
  );
`endif

  // Per-cycle fare increment from the distance and wait events seen this cycle.
  always_comb begin
`ifdef NIGHT_RATE_EN
    if (night_lvl_s) begin
      dist_rate_s = RATE_NIGHT_C;
    end else begin
      dist_rate_s = RATE_DIST_C;
    end
`else
    dist_rate_s = RATE_DIST_C;
`endif
    // The base-distance test uses the count before this event is added.
    if (dist_evt_s && (dist_r >= BASE_DIST_C)) begin
      dist_inc_s = dist_rate_s;
    end else begin
      dist_inc_s = {FARE_W{1'b0}};
    end
    if (wait_evt_s) begin
      wait_inc_s = RATE_WAIT_C;
    end else begin
      wait_inc_s = {FARE_W{1'b0}};
    end
    inc_s = dist_inc_s + wait_inc_s;
  end

  // Next-state, fare and distance logic of the trip state machine.
  always_comb begin
    state_nxt_s    = state_r;
    fare_nxt_s     = fare_r;
    dist_nxt_s     = dist_r;
    wait_rst_nxt_s = (state_r == HIRED) && !moving_lvl_s;
    case (state_r)
      VACANT: begin
        if (start_btn) begin
          state_nxt_s = HIRED;
          fare_nxt_s  = BASE_FARE_C;
          dist_nxt_s  = {DIST_W{1'b0}};
        end else begin
          state_nxt_s = VACANT;
        end
      end
      HIRED: begin
        // Events are credited even on the cycle stop_btn freezes the trip.
        fare_nxt_s = sat_add(fare_r, inc_s, FARE_MAX_C);
        if (dist_evt_s && (dist_r != DIST_SAT_C)) begin
          dist_nxt_s = dist_r + {{(DIST_W-1){1'b0}}, 1'b1};
        end else begin
          dist_nxt_s = dist_r;
        end
        if (stop_btn) begin
          state_nxt_s = STOPPED;
        end else begin
          state_nxt_s = HIRED;
        end
      end
      STOPPED: begin
        if (start_btn) begin
          state_nxt_s = HIRED;
          fare_nxt_s  = BASE_FARE_C;
          dist_nxt_s  = {DIST_W{1'b0}};
        end else if (clear_btn) begin
          state_nxt_s = VACANT;
          fare_nxt_s  = {FARE_W{1'b0}};
          dist_nxt_s  = {DIST_W{1'b0}};
        end else begin
          state_nxt_s = STOPPED;
        end
      end
      default: begin
        state_nxt_s = VACANT;
        fare_nxt_s  = {FARE_W{1'b0}};
        dist_nxt_s  = {DIST_W{1'b0}};
      end
    endcase
  end

  // State, fare, distance and wait-hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= VACANT;
      fare_r     <= {FARE_W{1'b0}};
      dist_r     <= {DIST_W{1'b0}};
      wait_rst_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      fare_r     <= fare_nxt_s;
      dist_r     <= dist_nxt_s;
      wait_rst_r <= wait_rst_nxt_s;
    end
  end

  assign fare           = fare_r;
  assign dist_cnt       = dist_r;
  assign state_o        = state_r;
  assign wait_cnt_rst_n = wait_rst_r;

endmodule
